// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmitter.
package i2s_pkg;

   localparam int unsigned I2S_DW = 24;

   // Word-select level that marks the left channel.
   localparam logic I2S_LEFT = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } i2s_tx_state_t;

   // Stereo frame at the default width; the top re-declares it at its own DW.
   typedef struct packed {
      logic [I2S_DW-1:0] left;
      logic [I2S_DW-1:0] right;
   } i2s_sample_t;

endpackage

// File: rtl/i2s_edge_detect.sv
// Registers the clk-synchronous sclk/lrclk levels and flags their edges.
// Reset leaves lrclk_q at the right-channel level so a reset in a right slot raises no edge.
module i2s_edge_detect
   import i2s_pkg::*;
(
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic sclk_i,
   input  logic lrclk_i,
   output logic sclk_fall_o,
   output logic lr_fall_o,
   output logic lr_rise_o
);

   logic sclk_q;
   logic lrclk_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         sclk_q  <= 1'b0;
         lrclk_q <= ~I2S_LEFT;
      end else begin
         sclk_q  <= sclk_i;
         lrclk_q <= lrclk_i;
      end
   end

   assign sclk_fall_o = sclk_q & ~sclk_i;
   assign lr_fall_o   = (lrclk_q != I2S_LEFT) & (lrclk_i == I2S_LEFT);
   assign lr_rise_o   = (lrclk_q == I2S_LEFT) & (lrclk_i != I2S_LEFT);

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-frame buffer, MSB-first on sclk falls with a one-bit delay.
// A frame goes out at the next left start; s_tready drops while the buffer is full except on the unload cycle.
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int DW = I2S_DW
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          en_i,
   input  logic          sclk_i,
   input  logic          lrclk_i,
   input  logic [2*DW-1:0] s_tdata_i,
   input  logic          s_tvalid_i,
   output logic          s_tready_o,
   output logic          sdata_o,
   output logic          underrun_o
);

   typedef struct packed {
      logic [DW-1:0] left;
      logic [DW-1:0] right;
   } sample_t;

   logic sclk_fall;
   logic lr_fall;
   logic lr_rise;

   i2s_edge_detect u_edge (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .sclk_i      (sclk_i),
      .lrclk_i     (lrclk_i),
      .sclk_fall_o (sclk_fall),
      .lr_fall_o   (lr_fall),
      .lr_rise_o   (lr_rise)
   );

   sample_t buf_q;
   sample_t buf_d;
   logic    buf_full_q;
   logic    buf_full_d;
   logic    unload;
   logic    accept;

   assign unload     = lr_fall & en_i;
   assign s_tready_o = ~buf_full_q | unload;
   assign accept     = s_tvalid_i & s_tready_o;

   // A write on the unload cycle refills the slot the outgoing frame just vacated.
   always_comb begin
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      if (accept) begin
         buf_d      = sample_t'(s_tdata_i);
         buf_full_d = 1'b1;
      end else if (unload) begin
         buf_full_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         buf_q      <= '0;
         buf_full_q <= 1'b0;
      end else begin
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
      end
   end

   i2s_tx_state_t state_q;
   logic [DW-1:0] shift_q;
   logic [DW-1:0] right_q;
   logic          sdata_q;
   logic          underrun_q;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         right_q    <= '0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else if (!en_i) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         sdata_q    <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         // Loads take priority over a coincident sclk fall, which yields the one-bit delay.
         if (lr_fall) begin
            state_q <= LEFT;
            if (buf_full_q) begin
               shift_q <= buf_q.left;
               right_q <= buf_q.right;
            end else begin
               shift_q    <= '0;
               right_q    <= '0;
               underrun_q <= 1'b1;
            end
         end else if (lr_rise) begin
            if (state_q == LEFT) begin
               state_q <= RIGHT;
               shift_q <= right_q;
            end
         end else if (sclk_fall && (state_q != IDLE)) begin
            sdata_q <= shift_q[DW-1];
            shift_q <= {shift_q[DW-2:0], 1'b0};
         end
      end
   end

   assign sdata_o    = sdata_q;
   assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboarded bench for i2s_tx driven by a modelled clock generator (sclk = clk/4, 32-bit slots).
module tb_i2s_tx;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        sclk;
   logic        lrclk;
   logic [47:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic        sdata;
   logic        underrun;
   logic [7:0]  cnt;

   int          errors = 0;
   int          checks = 0;
   logic [47:0] exp_q[$];
   bit          mon_en = 1'b0;

   assign sclk  = cnt[1];
   assign lrclk = cnt[7];

   i2s_tx #(.DW(24)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .en_i       (en),
      .sclk_i     (sclk),
      .lrclk_i    (lrclk),
      .s_tdata_i  (s_tdata),
      .s_tvalid_i (s_tvalid),
      .s_tready_o (s_tready),
      .sdata_o    (sdata),
      .underrun_o (underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Clock generator: starts in the right-channel phase so reset release raises no lrclk edge.
   initial begin
      cnt = 8'd192;
      forever begin
         @(posedge clk);
         #2 cnt = cnt + 8'd1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #3;
      end
   endtask

   task automatic wait_cnt(input logic [7:0] v);
      for (int n = 0; n < 300; n++) begin
         if (cnt == v) break;
         tick(1);
      end
   endtask

   task automatic send(input logic [47:0] d);
      bit got = 1'b0;
      s_tdata  = d;
      s_tvalid = 1'b1;
      for (int n = 0; n < 700 && !got; n++) begin
         @(negedge clk);
         got = (s_tready === 1'b1);
         @(posedge clk);
         #3;
      end
      if (got) begin
         exp_q.push_back(d);
      end else begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no s_tready expected accept of %h", d);
      end
      s_tvalid = 1'b0;
   endtask

   // Monitor and reference model, evaluated at negedge on values settled after the last posedge.
   initial begin
      logic        lr_p, sc_p, lrf, lrr, scr;
      logic        quiet, ur_exp, is_left, coll;
      int          st;
      int          idx;
      logic [47:0] cur;
      logic [31:0] word, ew;
      #1;
      lr_p = lrclk; sc_p = sclk;
      quiet = 1'b1; ur_exp = 1'b0; is_left = 1'b0; coll = 1'b0;
      st = 0; idx = 0; cur = '0; word = '0;
      forever begin
         @(negedge clk);
         lrf  = lr_p & ~lrclk;
         lrr  = ~lr_p & lrclk;
         scr  = ~sc_p & sclk;
         lr_p = lrclk;
         sc_p = sclk;
         if (mon_en) begin
            check("underrun", {31'd0, underrun}, {31'd0, ur_exp});
            if (quiet) check("sdata_quiet", {31'd0, sdata}, 32'd0);
            check("s_tready", {31'd0, s_tready},
                  {31'd0, (exp_q.size() == 0) || (lrf && en)});
         end
         ur_exp = 1'b0;
         if (!rst_n) begin
            exp_q.delete();
            st = 0;
            coll = 1'b0;
         end else if (!en) begin
            st = 0;
            coll = 1'b0;
         end else if (lrf) begin
            st = 1;
            if (exp_q.size() > 0) begin
               cur = exp_q.pop_front();
            end else begin
               cur = '0;
               ur_exp = 1'b1;
            end
            coll = 1'b1; is_left = 1'b1; idx = 0; word = '0;
         end else if (lrr && st == 1) begin
            st = 2;
            coll = 1'b1; is_left = 1'b0; idx = 0; word = '0;
         end else if (scr && coll) begin
            word = {word[30:0], sdata};
            idx++;
            if (idx == 32) begin
               coll = 1'b0;
               if (is_left) begin
                  ew = {1'b0, cur[47:24], 7'd0};
                  check("left_slot", word, ew);
               end else begin
                  ew = {1'b0, cur[23:0], 7'd0};
                  check("right_slot", word, ew);
               end
            end
         end
         quiet = (st == 0);
      end
   end

   initial begin
      rst_n    = 1'b0;
      en       = 1'b1;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      tick(3);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Idle after reset: zero slots and one underrun per frame.
      tick(600);

      // Single frame.
      send({24'hA5A5A5, 24'h5A5A5A});
      tick(600);

      // Streaming with s_tvalid held; later accepts coincide with unload.
      send({24'h800000, 24'h7FFFFF});
      send({24'h000001, 24'hFFFFFF});
      send({24'h123456, 24'h654321});
      tick(800);

      // Reset mid right slot with a frame buffered: buffer is cleared.
      send({24'h111111, 24'h222222});
      send({24'h333333, 24'h444444});
      wait_cnt(8'd192);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      send({24'hABCDEF, 24'hFEDCBA});
      tick(600);

      // Enable dropped mid left slot, raised in the right phase.
      send({24'hC0FFEE, 24'hBADC0D});
      send({24'h765432, 24'h0F0F0F});
      wait_cnt(8'd64);
      en = 1'b0;
      wait_cnt(8'd200);
      en = 1'b1;
      tick(600);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
